regfile_access_ctrl: RTL and testbench

// - Initiator side of the 16x20-bit register_file: drives its read selects and its write port.
// - Accepts operand-read requests from decode and returns registered operands to execute.
// - Buffers execute write-backs in a FIFO and drains one entry per cycle into the register file.
// - Keeps a per-register pending-write scoreboard and stalls RAW/WAW hazards.

---
 rtl/regfile_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: operand issue, RAW/WAW pending scoreboard, write-back FIFO and drain FSM.
// Define REGFILE_FORWARD_EN to let read sources take the FIFO head value instead of stalling.
module regfile_access_ctrl #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_src1,
  input  logic [ADDR_W-1:0] rd_src2,
  input  logic [ADDR_W-1:0] rd_dst,
  input  logic              rd_dst_en,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              drain,
  output logic              drain_done,
  output logic [DATA_W-1:0] rf_write,
  output logic [ADDR_W-1:0] rf_w_select,
  output logic              rf_w,
  output logic [ADDR_W-1:0] rf_r1_select,
  output logic [ADDR_W-1:0] rf_r2_select,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DRAINED = 2'd2} state_t;
  state_t state, state_nxt;
  logic   run_en;

  logic [ADDR_W-1:0] dest_mem [WB_DEPTH];
  logic [DATA_W-1:0] data_mem [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  logic [NREG-1:0]   pending, pending_nxt;
  logic              fwd1, fwd2, hazard, issue;

  logic              vld_p1;
  logic [DATA_W-1:0] op1_p1, op2_p1;

  assign rf_r1_select = rd_src1;
  assign rf_r2_select = rd_src2;

  // Write-back FIFO: the head is written to the register file every cycle it exists.
  assign head_dest   = dest_mem[rd_ptr];
  assign head_data   = data_mem[rd_ptr];
  assign wb_ready    = (count < DEPTH_C);
  assign push        = wb_valid & wb_ready;
  assign pop         = (count != '0);
  assign rf_w        = pop;
  assign rf_write    = head_data;
  assign rf_w_select = head_dest;

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= wb_dest;
      data_mem[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Hazard detection; a forwarded source is satisfied by the head being written this cycle.
`ifdef REGFILE_FORWARD_EN
  assign fwd1 = rf_w & (rd_src1 == head_dest);
  assign fwd2 = rf_w & (rd_src2 == head_dest);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign hazard       = (pending[rd_src1] & ~fwd1) | (pending[rd_src2] & ~fwd2) |
                        (rd_dst_en & pending[rd_dst]);
  assign rd_req_ready = run_en & ~hazard & (~vld_p1 | op_ready);
  assign issue        = rd_req_valid & rd_req_ready;

  // A reservation landing on the register being retired this cycle keeps it pending.
  always_comb begin
    pending_nxt = pending;
    if (pop)               pending_nxt[head_dest] = 1'b0;
    if (issue & rd_dst_en) pending_nxt[rd_dst]    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Stage p1: registered operands towards execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      op1_p1 <= '0;
      op2_p1 <= '0;
    end else if (issue) begin
      vld_p1 <= 1'b1;
      op1_p1 <= fwd1 ? head_data : rf_read1;
      op2_p1 <= fwd2 ? head_data : rf_read2;
    end else if (op_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign op_valid = vld_p1;
  assign op1      = op1_p1;
  assign op2      = op2_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain)                                state_nxt = RUN;
        else if ((count == '0) && (pending == '0)) state_nxt = DRAINED;
      end
      DRAINED: if (!drain) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    run_en     = (state == RUN);
    drain_done = (state == DRAINED);
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus a randomized run against a queue/array model.
// The bench also plays the 16x20 register file the controller drives.
module tb_regfile_access_ctrl;
`ifdef REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int WB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [3:0]  rd_src1 = '0, rd_src2 = '0, rd_dst = '0;
  logic        rd_dst_en = 1'b0;
  logic        op_valid, op_ready = 1'b0;
  logic [19:0] op1, op2;
  logic        wb_valid = 1'b0, wb_ready;
  logic [3:0]  wb_dest = '0;
  logic [19:0] wb_data = '0;
  logic        drain = 1'b0, drain_done;
  logic [19:0] rf_write, rf_read1, rf_read2;
  logic [3:0]  rf_w_select, rf_r1_select, rf_r2_select;
  logic        rf_w;

  logic [19:0] rf_mem [16];
  assign rf_read1 = rf_mem[rf_r1_select];
  assign rf_read2 = rf_mem[rf_r2_select];

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_src1(rd_src1), .rd_src2(rd_src2), .rd_dst(rd_dst), .rd_dst_en(rd_dst_en),
    .op_valid(op_valid), .op_ready(op_ready), .op1(op1), .op2(op2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .drain(drain), .drain_done(drain_done),
    .rf_write(rf_write), .rf_w_select(rf_w_select), .rf_w(rf_w),
    .rf_r1_select(rf_r1_select), .rf_r2_select(rf_r2_select),
    .rf_read1(rf_read1), .rf_read2(rf_read2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending set, FIFO as a queue, mode 0=RUN 1=DRAIN 2=DRAINED.
  typedef struct packed {logic [3:0] d; logic [19:0] v;} wb_t;
  wb_t         m_q[$];
  logic [15:0] m_pend;
  int          m_state;
  bit          m_vld;
  logic [19:0] m_op1, m_op2;

  function automatic logic [19:0] rf_init(int i);
    return 20'(i * 4099 + 7);
  endfunction

  function automatic bit m_fwd(logic [3:0] s);
    return FWD && (m_q.size() > 0) && (m_q[0].d == s);
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = (m_pend[rd_src1] && !m_fwd(rd_src1)) || (m_pend[rd_src2] && !m_fwd(rd_src2)) ||
         (rd_dst_en && m_pend[rd_dst]);
    return (m_state == 0) && !hz && (!m_vld || op_ready);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend  = '0;
    m_state = 0;
    m_vld   = 1'b0;
    m_op1   = '0;
    m_op2   = '0;
  endtask

  // Advance one clock; the model (and the register file) update just after the edge.
  task automatic tick();
    bit iss, psh, pp;
    wb_t hd, nw;
    logic [19:0] n1, n2;
    logic [3:0] dst;
    bit den;
    int nst;
    iss = rd_req_valid && m_ready();
    psh = wb_valid && (m_q.size() < WB_DEPTH);
    pp  = (m_q.size() > 0);
    hd  = pp ? m_q[0] : '0;
    n1  = m_fwd(rd_src1) ? hd.v : rf_mem[rd_src1];
    n2  = m_fwd(rd_src2) ? hd.v : rf_mem[rd_src2];
    nw.d = wb_dest;
    nw.v = wb_data;
    dst = rd_dst;
    den = rd_dst_en;
    case (m_state)
      0:       nst = drain ? 1 : 0;
      1:       nst = !drain ? 0 : ((m_q.size() == 0 && m_pend == '0) ? 2 : 1);
      default: nst = drain ? 2 : 0;
    endcase
    @(posedge clk);
    #1;
    if (pp) begin
      rf_mem[hd.d] = hd.v;
      void'(m_q.pop_front());
      m_pend[hd.d] = 1'b0;
    end
    if (psh) m_q.push_back(nw);
    if (iss) begin
      m_vld = 1'b1;
      m_op1 = n1;
      m_op2 = n2;
      if (den) m_pend[dst] = 1'b1;
    end else if (op_ready) begin
      m_vld = 1'b0;
    end
    m_state = nst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %0b want 0", op_valid); end
    n_chk++; if (op1 !== 20'd0 || op2 !== 20'd0) begin n_fail++; $display("FAIL reset_ops got %0h/%0h want 0/0", op1, op2); end
    n_chk++; if (rf_w !== 1'b0) begin n_fail++; $display("FAIL reset_rf_w got %0b want 0", rf_w); end
    n_chk++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_drain_done got %0b want 0", drain_done); end
    n_chk++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready got %0b want 1", wb_ready); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_issue();
    rd_src1 = 4'd0; rd_src2 = 4'd0; rd_dst_en = 1'b0; rd_req_valid = 1'b1; op_ready = 1'b0;
    #1;
    n_chk++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %0b want 1", rd_req_ready); end
    tick();
    rd_req_valid = 1'b0;
    #1;
    n_chk++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_op_valid got %0b want 1", op_valid); end
    n_chk++; if (op1 !== rf_init(0) || op2 !== rf_init(0)) begin n_fail++; $display("FAIL basic_ops got %0h/%0h want %0h", op1, op2, rf_init(0)); end
    op_ready = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    int nwait;
    rd_src1 = 4'd1; rd_src2 = 4'd2; rd_dst = 4'd3; rd_dst_en = 1'b1; rd_req_valid = 1'b1; op_ready = 1'b1;
    #1;
    n_chk++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL raw_reserve_ready got %0b want 1", rd_req_ready); end
    tick();
    rd_src1 = 4'd3; rd_src2 = 4'd0; rd_dst_en = 1'b0;
    #1;
    n_chk++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %0b want 0", rd_req_ready); end
    wb_valid = 1'b1; wb_dest = 4'd3; wb_data = 20'd1234;
    tick();
    wb_valid = 1'b0;
    #1;
    nwait = 0;
    while (rd_req_ready !== 1'b1 && nwait < 5) begin
      tick();
      #1;
      nwait++;
    end
    n_chk++; if (nwait !== (FWD ? 0 : 1)) begin n_fail++; $display("FAIL raw_stall_cycles got %0d want %0d", nwait, FWD ? 0 : 1); end
    tick();
    rd_req_valid = 1'b0;
    #1;
    n_chk++; if (op_valid !== 1'b1 || op1 !== 20'd1234) begin n_fail++; $display("FAIL raw_op1 got v=%0b %0d want v=1 1234", op_valid, op1); end
    tick();
  endtask

  task automatic test_wb_stream();
    logic [3:0]  d [4];
    logic [19:0] v [4];
    rd_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d[k] = 4'(7 + k);
      v[k] = 20'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_dest = d[k]; wb_data = v[k];
      #1;
      n_chk++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL wb_ready_%0d got %0b want 1", k, wb_ready); end
      if (k > 0) begin
        n_chk++;
        if (rf_w !== 1'b1 || rf_w_select !== d[k-1] || rf_write !== v[k-1]) begin
          n_fail++; $display("FAIL wb_order_%0d got w=%0b sel=%0d data=%0h want 1 %0d %0h", k, rf_w, rf_w_select, rf_write, d[k-1], v[k-1]);
        end
      end
      tick();
    end
    wb_valid = 1'b0;
    #1;
    n_chk++; if (rf_w !== 1'b1 || rf_w_select !== d[3]) begin n_fail++; $display("FAIL wb_last got w=%0b sel=%0d want 1 %0d", rf_w, rf_w_select, d[3]); end
    tick();
    #1;
    n_chk++; if (rf_w !== 1'b0) begin n_fail++; $display("FAIL wb_empty got %0b want 0", rf_w); end
    n_chk++; if (rf_mem[d[2]] !== v[2]) begin n_fail++; $display("FAIL wb_written got %0h want %0h", rf_mem[d[2]], v[2]); end
  endtask

  task automatic test_backpressure();
    op_ready = 1'b0; rd_src1 = 4'd11; rd_src2 = 4'd12; rd_dst_en = 1'b0; rd_req_valid = 1'b1;
    #1;
    n_chk++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got %0b want 1", rd_req_ready); end
    tick();
    rd_src1 = 4'd13; rd_src2 = 4'd14;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (rd_req_ready !== 1'b0 || op_valid !== 1'b1 || op1 !== rf_mem[11] || op2 !== rf_mem[12]) begin
        n_fail++; $display("FAIL bp_hold_%0d got rdy=%0b v=%0b %0h/%0h want 0 1 %0h/%0h", k, rd_req_ready, op_valid, op1, op2, rf_mem[11], rf_mem[12]);
      end
      tick();
    end
    op_ready = 1'b1;
    #1;
    n_chk++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", rd_req_ready); end
    tick();
    rd_req_valid = 1'b0;
    #1;
    n_chk++; if (op_valid !== 1'b1 || op1 !== rf_mem[13] || op2 !== rf_mem[14]) begin n_fail++; $display("FAIL bp_next_ops got %0h/%0h want %0h/%0h", op1, op2, rf_mem[13], rf_mem[14]); end
    tick();
  endtask

  task automatic test_drain();
    int n;
    op_ready = 1'b1; rd_src1 = 4'd0; rd_src2 = 4'd0; rd_dst = 4'd5; rd_dst_en = 1'b1; rd_req_valid = 1'b1;
    tick();
    rd_dst = 4'd6;
    tick();
    rd_req_valid = 1'b0; rd_dst_en = 1'b0; drain = 1'b1;
    tick();
    rd_req_valid = 1'b1;
    #1;
    n_chk++; if (rd_req_ready !== 1'b0 || drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_block got rdy=%0b done=%0b want 0 0", rd_req_ready, drain_done); end
    wb_valid = 1'b1; wb_dest = 4'd5; wb_data = 20'h5555;
    tick();
    wb_dest = 4'd6; wb_data = 20'h6666;
    tick();
    wb_valid = 1'b0;
    #1;
    n = 0;
    while (drain_done !== 1'b1 && n < 8) begin
      tick();
      #1;
      n++;
    end
    n_chk++; if (drain_done !== 1'b1 || n !== 2) begin n_fail++; $display("FAIL drain_done got %0b after %0d want 1 after 2", drain_done, n); end
    n_chk++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL drained_ready got %0b want 0", rd_req_ready); end
    drain = 1'b0;
    tick();
    #1;
    n_chk++; if (drain_done !== 1'b0 || rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_exit got done=%0b rdy=%0b want 0 1", drain_done, rd_req_ready); end
    rd_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b0; wb_valid = 1'b1; wb_dest = 4'd12; wb_data = 20'h0abcd;
    rd_src1 = 4'd0; rd_src2 = 4'd0; rd_dst = 4'd9; rd_dst_en = 1'b1; rd_req_valid = 1'b1;
    tick();
    wb_valid = 1'b0; rd_req_valid = 1'b0; rd_dst_en = 1'b0; rd_src1 = 4'd9;
    #1;
    n_chk++; if (rf_w !== 1'b1 || op_valid !== 1'b1 || rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre got w=%0b v=%0b rdy=%0b want 1 1 0", rf_w, op_valid, rd_req_ready); end
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (rf_w !== 1'b0 || op_valid !== 1'b0 || op1 !== 20'd0) begin n_fail++; $display("FAIL mid_reset got w=%0b v=%0b op1=%0h want 0 0 0", rf_w, op_valid, op1); end
    op_ready = 1'b1;
    #1;
    n_chk++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_pending_clear got %0b want 1", rd_req_ready); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 400; i++) begin
      rd_req_valid = ($urandom_range(0, 3) != 0);
      rd_src1   = 4'($urandom);
      rd_src2   = 4'($urandom);
      rd_dst    = 4'($urandom);
      rd_dst_en = $urandom_range(0, 1) == 1;
      op_ready  = ($urandom_range(0, 3) != 0);
      wb_valid  = $urandom_range(0, 1) == 1;
      wb_data   = 20'($urandom);
      wb_dest   = 4'($urandom);
      if (m_pend != '0 && $urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, 15);
        while (!m_pend[s[3:0]]) s = (s + 1) % 16;
        wb_dest = 4'(s);
      end
      drain = (i % 100) >= 75;
      #1;
      n_chk++; if (rd_req_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready @%0d got %0b want %0b", i, rd_req_ready, m_ready()); end
      n_chk++; if (op_valid !== m_vld) begin n_fail++; $display("FAIL rnd_op_valid @%0d got %0b want %0b", i, op_valid, m_vld); end
      if (m_vld) begin
        n_chk++; if (op1 !== m_op1 || op2 !== m_op2) begin n_fail++; $display("FAIL rnd_ops @%0d got %0h/%0h want %0h/%0h", i, op1, op2, m_op1, m_op2); end
      end
      n_chk++; if (wb_ready !== (m_q.size() < WB_DEPTH)) begin n_fail++; $display("FAIL rnd_wb_ready @%0d got %0b", i, wb_ready); end
      n_chk++; if (rf_w !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_rf_w @%0d got %0b want %0b", i, rf_w, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_chk++; if (rf_w_select !== m_q[0].d || rf_write !== m_q[0].v) begin n_fail++; $display("FAIL rnd_head @%0d got %0d/%0h want %0d/%0h", i, rf_w_select, rf_write, m_q[0].d, m_q[0].v); end
      end
      n_chk++; if (drain_done !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_drain_done @%0d got %0b want %0b", i, drain_done, m_state == 2); end
      n_chk++; if (rf_r1_select !== rd_src1 || rf_r2_select !== rd_src2) begin n_fail++; $display("FAIL rnd_rsel @%0d got %0d/%0d", i, rf_r1_select, rf_r2_select); end
      tick();
    end
    rd_req_valid = 1'b0; wb_valid = 1'b0; drain = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = rf_init(i);
    model_reset();
    test_reset();
    test_basic_issue();
    test_raw();
    test_wb_stream();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
